// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   state_e   : arbiter FSM states
//   PORT_IF / PORT_DM : grant encoding (0 = fetch, 1 = load/store)
//   cnt_width : latency counter width, clog2(latency) with a floor of 1
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned latency);
    int unsigned w;
    w = $clog2(latency);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between the fetch and load/store requesters.
// Build option: MEM_ARB_RR_EN adds the last_grant input and alternates the
// winner on simultaneous requests; without it DM always beats IF.
// Ports:
//   if_req, dm_req : pending requests
//   last_grant     : port granted last (MEM_ARB_RR_EN builds only)
//   grant_c        : winning port index (valid when any_req_c)
//   any_req_c      : at least one request pending
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_c,
  output logic any_req_c
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    any_req_c = if_req | dm_req;
    grant_c   = PORT_IF;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
      grant_c = ~last_grant;
`else
      grant_c = PORT_DM;
`endif
    end else if (dm_req) begin
      grant_c = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch
// port (IF) and the load/store port (DM). Each access runs
// IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> DONE, with a one-cycle done
// pulse and registered read data per requester.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr/if_done/if_rdata  : fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata/dm_done/dm_rdata : load/store requester
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata     : memory side
//   busy                             : FSM not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_done,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);

  state_e                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  grant_q,    grant_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  we_q,       we_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_done_q,  if_done_d;
  logic                  dm_done_q,  dm_done_d;
  logic                  mem_en_q,   mem_en_d;
  logic                  mem_we_q,   mem_we_d;
  logic                  busy_q,     busy_d;
  logic                  grant_c;
  logic                  any_req_c;
`ifdef MEM_ARB_RR_EN
  logic                  last_grant_q, last_grant_d;
`endif

  mem_arb_grant u_grant (
    .if_req     (if_req),
    .dm_req     (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant_c    (grant_c),
    .any_req_c  (any_req_c)
  );

  // Next-state, datapath latches and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d = ACCESS;
          grant_d = grant_c;
          cnt_d   = CNT_W'(MEM_LATENCY - 32'd1);
`ifdef MEM_ARB_RR_EN
          last_grant_d = grant_c;
`endif
          if (grant_c == PORT_DM) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        // Counter hits zero in the cycle where mem_rdata becomes valid.
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_q == PORT_DM) dm_rdata_d = mem_rdata;
            else                    if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    mem_en_d  = (state_d == ACCESS);
    mem_we_d  = (state_d == ACCESS) && we_d;
    if_done_d = (state_d == DONE) && (grant_d == PORT_IF);
    dm_done_d = (state_d == DONE) && (grant_d == PORT_DM);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= PORT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= PORT_IF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
